// File: rtl/alu_arbiter.sv
// Purpose : round-robin arbiter sharing one external combinational ALU between two requesters.
// Latency : request accepted at edge T -> rsp_valid from edge T+1; at most one operation per 3 cycles.
// Backpressure: requests are accepted only in IDLE; a response is held stable until rsp_ready.
//
// Ports:
//   clk, rst_n                           clock and async active-low reset
//   req{0,1}_valid/ready/a/b/op          request channels (valid/ready, operands and opcode)
//   alu_a/b/op -> ALU, alu_result/flags <- ALU   registered drive of the external ALU
//   rsp_valid/ready/id/result/flags      tagged response channel, flags = {eq, grt, neg, zero}
//   busy                                 high whenever an operation is in flight
module alu_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [OP_WIDTH-1:0]   req1_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_neg,
    input  logic                  alu_grt,
    input  logic                  alu_eq,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [OP_WIDTH-1:0]   op;
    } alu_req_t;

    state_t   state;
    state_t   state_nxt;
    logic     last_grant;
    logic     grant_vld;
    logic     grant_id;
    logic     accept;
    logic     id_q;
    alu_req_t sel_req;

    // Grant: a lone requester wins outright; on a tie the one that did not win last time wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant;
        end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && grant_vld;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;
    assign busy       = (state != IDLE);

    assign sel_req = grant_id ? alu_req_t'{req1_a, req1_b, req1_op}
                              : alu_req_t'{req0_a, req0_b, req0_op};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:                   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands persist after the operation; response fields persist after rsp_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= sel_req.a;
                        alu_b      <= sel_req.b;
                        alu_op     <= sel_req.op;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= {alu_eq, alu_grt, alu_neg, alu_zero};
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : self-checking bench for alu_arbiter with a transaction-level reference model.
// Latency : checks accept->response timing, round-robin order and response hold.
// Backpressure: exercises rsp_ready low while a second requester waits.
module tb_alu_arbiter;

    localparam int DW = 16;
    localparam int OW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OW-1:0] req0_op, req1_op;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [OW-1:0] alu_op;
    logic          alu_zero, alu_neg, alu_grt, alu_eq;
    logic          rsp_valid, rsp_ready, rsp_id, busy;
    logic [DW-1:0] rsp_result;
    logic [3:0]    rsp_flags;
    logic [19:0]   alu_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state (transaction level).
    int            m_phase;      // 0 idle, 1 operation issued, 2 response pending
    logic          m_last;
    logic          m_id;
    logic [DW-1:0] m_a, m_b;
    logic [OW-1:0] m_op;
    logic          l_id;
    logic [DW-1:0] l_result;
    logic [3:0]    l_flags;
    int            acc_id[$];
    int            acc_cyc[$];
    int            rel_cyc;

    always #5 clk = ~clk;

    // Behavioural external ALU: {eq, grt, neg, zero, result}.
    function automatic logic [19:0] ref_alu(logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
        logic [DW-1:0] r;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            default: r = a;
        endcase
        return {a == b, $signed(a) > $signed(b), r[DW-1], r == '0, r};
    endfunction

    assign alu_out    = ref_alu(alu_a, alu_b, alu_op);
    assign alu_result = alu_out[15:0];
    assign alu_zero   = alu_out[16];
    assign alu_neg    = alu_out[17];
    assign alu_grt    = alu_out[18];
    assign alu_eq     = alu_out[19];

    alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_grt(alu_grt), .alu_eq(alu_eq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_last   = 1'b1;
        m_id     = 1'b0;
        m_a      = '0;
        m_b      = '0;
        m_op     = '0;
        l_id     = 1'b0;
        l_result = '0;
        l_flags  = '0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model past the rising edge.
    task automatic tick();
        logic er0, er1, hs0, hs1, hsr;
        logic [19:0] r;
        @(negedge clk);
        er0 = 1'b0;
        er1 = 1'b0;
        if (m_phase == 0) begin
            if (req0_valid && req1_valid) begin
                er0 = (m_last == 1'b1);
                er1 = (m_last == 1'b0);
            end else begin
                er0 = req0_valid;
                er1 = req1_valid;
            end
        end
        chk("req0_ready", req0_ready, er0);
        chk("req1_ready", req1_ready, er1);
        chk("ready_excl", req0_ready & req1_ready, 0);
        chk("busy", busy, m_phase != 0);
        chk("rsp_valid", rsp_valid, m_phase == 2);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", alu_op, m_op);
        r = ref_alu(m_a, m_b, m_op);
        if (m_phase == 2) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_result", rsp_result, r[15:0]);
            chk("rsp_flags", rsp_flags, r[19:16]);
        end else begin
            chk("hold_id", rsp_id, l_id);
            chk("hold_result", rsp_result, l_result);
            chk("hold_flags", rsp_flags, l_flags);
        end
        hs0 = rst_n && er0 && req0_valid;
        hs1 = rst_n && er1 && req1_valid;
        hsr = rst_n && (m_phase == 2) && rsp_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            case (m_phase)
                0: if (hs0 || hs1) begin
                    m_id   = hs1;
                    m_a    = hs1 ? req1_a : req0_a;
                    m_b    = hs1 ? req1_b : req0_b;
                    m_op   = hs1 ? req1_op : req0_op;
                    m_last = hs1;
                    m_phase = 1;
                    acc_id.push_back(int'(hs1));
                    acc_cyc.push_back(cyc);
                    if (hs1) req1_valid = 1'b0;
                    else     req0_valid = 1'b0;
                end
                1: m_phase = 2;
                default: if (hsr) begin
                    m_phase  = 0;
                    l_id     = m_id;
                    l_result = r[15:0];
                    l_flags  = r[19:16];
                    rel_cyc  = cyc;
                end
            endcase
        end
    endtask

    task automatic set_req(int n, logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
        if (n == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
    endtask

    task automatic rand_req(int n);
        set_req(n, DW'($urandom), DW'($urandom), OW'($urandom_range(0, 31)));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (m_phase == 0 && !req0_valid && !req1_valid) break;
            tick();
        end
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b0;
        rel_cyc = 0;
        model_reset();
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;

        // Single request: 2 + 3.
        rsp_ready = 1'b1;
        set_req(0, 16'd2, 16'd3, 5'd0);
        tick();
        chk("single_alu_a", alu_a, 16'd2);
        chk("single_alu_b", alu_b, 16'd3);
        tick();
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_result", rsp_result, 16'd5);
        chk("single_flags", rsp_flags, 4'b0000);
        tick();
        chk("single_done", rsp_valid, 0);

        // Simultaneous requests after reset: req0 wins the first tie.
        apply_reset();
        set_req(0, 16'd10, 16'd5, 5'd1);
        set_req(1, 16'd6, 16'd6, 5'd1);
        tick();
        tick();
        chk("tie0_id", rsp_id, 0);
        chk("tie0_result", rsp_result, 16'd5);
        chk("tie0_flags", rsp_flags, 4'b0100);
        tick();
        tick();
        tick();
        chk("tie1_id", rsp_id, 1);
        chk("tie1_result", rsp_result, 16'd0);
        chk("tie1_flags", rsp_flags, 4'b1001);
        tick();

        // Saturation: both continuously valid, grants must alternate every 3 cycles.
        acc_id.delete();
        acc_cyc.delete();
        for (int i = 0; i < 18; i++) begin
            if (!req0_valid) rand_req(0);
            if (!req1_valid) rand_req(1);
            tick();
        end
        chk("sat_count", acc_id.size() >= 6, 1);
        if (acc_id.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("sat_id", acc_id[i], i % 2);
                if (i > 0) chk("sat_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
            end
        end
        drain();

        // Backpressure with req1 waiting, then signed subtraction -4 - 3.
        rsp_ready = 1'b0;
        rand_req(0);
        tick();
        set_req(1, 16'hFFFC, 16'd3, 5'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("bp_req1_ready", req1_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("bp_acc_id", acc_id[$], 1);
        chk("bp_acc_gap", acc_cyc[$] - rel_cyc, 1);
        tick();
        chk("neg_id", rsp_id, 1);
        chk("neg_result", rsp_result, 16'hFFF9);
        chk("neg_flags", rsp_flags, 4'b0010);
        tick();

        // Reset during EXEC discards the operation; next tie goes to req0.
        rand_req(0);
        rand_req(1);
        tick();
        rand_req(0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        chk("mid_rst_busy", busy, 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_grant", acc_id[$], 0);
        chk("post_rst_gap", acc_cyc[$], cyc);
        drain();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (!req0_valid && $urandom_range(0, 2) != 0) rand_req(0);
            if (!req1_valid && $urandom_range(0, 2) != 0) rand_req(1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
